// File: rtl/btn_seq_det_pkg.sv
// Shared types and sizing helpers for the button sequence detector.
package btn_seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/btn_edge_enc.sv
// Press-edge detector: normalises button polarity, finds rising edges and
// encodes a single press into a key index.
module btn_edge_enc
  import btn_seq_det_pkg::*;
#(
  parameter int unsigned BT_WIDTH = 8,
  parameter logic        BTN_POL  = 1'b1,
  parameter int unsigned KW       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BT_WIDTH-1:0] btn_in,
  output logic                key_vld,
  output logic [KW-1:0]       key_idx,
  output logic                multi_vld
);

  logic [BT_WIDTH-1:0] lvl_s;
  logic [BT_WIDTH-1:0] edge_s;
  logic [BT_WIDTH-1:0] low_clr_s;
  logic [BT_WIDTH-1:0] btn_prev_r;

  // Polarity normalisation and rising-edge extraction.
  always_comb begin
    if (BTN_POL) begin
      lvl_s = btn_in;
    end else begin
      lvl_s = ~btn_in;
    end
    edge_s    = lvl_s & ~btn_prev_r;
    // Clearing the lowest set bit leaves something only when two or more rose.
    low_clr_s = edge_s & (edge_s - BT_WIDTH'(1));
    multi_vld = |low_clr_s;
    key_vld   = (|edge_s) & ~(|low_clr_s);
  end

  // One-hot to index; only meaningful when key_vld is set.
  always_comb begin
    key_idx = {KW{1'b0}};
    for (int i = 0; i < int'(BT_WIDTH); i++) begin
      key_idx = key_idx | (edge_s[i] ? KW'(unsigned'(i)) : {KW{1'b0}});
    end
  end

  // Level history; a button held through reset is captured so it never reads as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev_r <= lvl_s;
    end else begin
      btn_prev_r <= lvl_s;
    end
  end

endmodule

// File: rtl/btn_seq_det.sv
// Button sequence detector: matches single presses against a key code,
// with inactivity timeout and a timed match indicator.
module btn_seq_det
  import btn_seq_det_pkg::*;
#(
  parameter int unsigned BT_WIDTH = 8,
  parameter logic        BTN_POL  = 1'b1,
  parameter int unsigned SEQ_LEN  = 4,
  parameter logic [31:0] SEQ      = 32'h0000_0099,
  parameter int unsigned TO_CYC   = 150_000_000,
  parameter int unsigned HOLD_CYC = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BT_WIDTH-1:0] btn_in,
  output logic                det_pulse,
  output logic                det_led,
  output logic                err_pulse,
  output logic [3:0]          progress
);

  localparam int unsigned KW = cnt_width(BT_WIDTH);
  localparam int unsigned TW = cnt_width(TO_CYC);
  localparam int unsigned HW = cnt_width(HOLD_CYC);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 32'd1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 32'd1);
  localparam logic [3:0]    LAST_P    = 4'(SEQ_LEN - 32'd1);

  logic          key_vld_s;
  logic [KW-1:0] key_idx_s;
  logic          multi_vld_s;
  logic [KW-1:0] exp_key_s;
  logic [KW-1:0] first_key_s;

  state_t        state_r;
  logic [3:0]    progress_r;
  logic [TW-1:0] to_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic          det_pulse_r;
  logic          det_led_r;
  logic          err_pulse_r;

  btn_edge_enc #(
    .BT_WIDTH (BT_WIDTH),
    .BTN_POL  (BTN_POL),
    .KW       (KW)
  ) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .key_vld   (key_vld_s),
    .key_idx   (key_idx_s),
    .multi_vld (multi_vld_s)
  );

  // Expected key at the current position and the code's first key.
  always_comb begin
    exp_key_s   = SEQ[KW*int'(progress_r) +: KW];
    first_key_s = SEQ[KW-1:0];
  end

  // Sequence FSM with progress, timeout and hold counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      progress_r  <= 4'd0;
      to_cnt_r    <= {TW{1'b0}};
      hold_cnt_r  <= {HW{1'b0}};
      det_pulse_r <= 1'b0;
      det_led_r   <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      det_pulse_r <= 1'b0;
      err_pulse_r <= 1'b0;
      case (state_r)
        S_IDLE, S_RUN: begin
          if (multi_vld_s) begin
            err_pulse_r <= 1'b1;
            progress_r  <= 4'd0;
            to_cnt_r    <= {TW{1'b0}};
            state_r     <= S_IDLE;
          end else if (key_vld_s) begin
            to_cnt_r <= {TW{1'b0}};
            if (key_idx_s == exp_key_s) begin
              if (progress_r == LAST_P) begin
                det_pulse_r <= 1'b1;
                det_led_r   <= 1'b1;
                progress_r  <= 4'd0;
                hold_cnt_r  <= {HW{1'b0}};
                state_r     <= S_HOLD;
              end else begin
                progress_r <= progress_r + 4'd1;
                state_r    <= S_RUN;
              end
            end else begin
              err_pulse_r <= (progress_r != 4'd0);
              // Only the first key is retried; no deeper overlap search.
              if (key_idx_s == first_key_s) begin
                progress_r <= 4'd1;
                state_r    <= S_RUN;
              end else begin
                progress_r <= 4'd0;
                state_r    <= S_IDLE;
              end
            end
          end else if (state_r == S_RUN) begin
            if (to_cnt_r == TO_LAST) begin
              progress_r <= 4'd0;
              to_cnt_r   <= {TW{1'b0}};
              state_r    <= S_IDLE;
            end else begin
              to_cnt_r <= to_cnt_r + TW'(1);
            end
          end else begin
            to_cnt_r <= {TW{1'b0}};
          end
        end
        S_HOLD: begin
          to_cnt_r <= {TW{1'b0}};
          if (hold_cnt_r == HOLD_LAST) begin
            det_led_r  <= 1'b0;
            hold_cnt_r <= {HW{1'b0}};
            state_r    <= S_IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          progress_r <= 4'd0;
          to_cnt_r   <= {TW{1'b0}};
          hold_cnt_r <= {HW{1'b0}};
          det_led_r  <= 1'b0;
        end
      endcase
    end
  end

  assign det_pulse = det_pulse_r;
  assign det_led   = det_led_r;
  assign err_pulse = err_pulse_r;
  assign progress  = progress_r;

endmodule

// File: tb/tb_btn_seq_det.sv
// Self-checking bench for btn_seq_det: directed scenarios plus randomized
// button activity, compared every cycle against a behavioural model.
module tb_btn_seq_det;

  localparam int          BT_WIDTH = 8;
  localparam int          SEQ_LEN  = 4;
  localparam int          TO_CYC   = 100;
  localparam int          HOLD_CYC = 20;
  localparam logic [31:0] SEQ      = 32'h0000_0099;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn_in;
  logic       det_pulse;
  logic       det_led;
  logic       err_pulse;
  logic [3:0] progress;

  int total = 0;
  int bad   = 0;

  // model state
  int         m_prog;
  bit         m_hold;
  int         m_hold_age;
  int         m_idle;
  logic [7:0] m_prev;
  bit         e_pulse;
  bit         e_err;
  bit         e_led;

  always #5 clk = ~clk;

  btn_seq_det #(
    .BT_WIDTH (BT_WIDTH),
    .BTN_POL  (1'b1),
    .SEQ_LEN  (SEQ_LEN),
    .SEQ      (SEQ),
    .TO_CYC   (TO_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .det_pulse (det_pulse),
    .det_led   (det_led),
    .err_pulse (err_pulse),
    .progress  (progress)
  );

  function automatic int seq_key(input int i);
    logic [31:0] s;
    s = SEQ >> (3 * i);
    return int'(s & 32'h7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs present before it.
  task automatic model_clock();
    logic [7:0] ev;
    int n;
    int k;
    e_pulse = 1'b0;
    e_err   = 1'b0;
    if (!rst_n) begin
      m_prev = btn_in; m_prog = 0; m_hold = 1'b0; m_hold_age = 0; m_idle = 0; e_led = 1'b0;
      return;
    end
    ev     = btn_in & ~m_prev;
    m_prev = btn_in;
    n      = $countones(ev);
    k      = 0;
    for (int i = 0; i < 8; i++) if (ev[i]) k = i;
    if (m_hold) begin
      m_hold_age++;
      if (m_hold_age == HOLD_CYC) begin
        m_hold = 1'b0;
        e_led  = 1'b0;
      end
    end else if (n >= 2) begin
      e_err = 1'b1; m_prog = 0; m_idle = 0;
    end else if (n == 1) begin
      m_idle = 0;
      if (k == seq_key(m_prog)) begin
        if (m_prog + 1 == SEQ_LEN) begin
          e_pulse = 1'b1; e_led = 1'b1; m_hold = 1'b1; m_hold_age = 0; m_prog = 0;
        end else begin
          m_prog++;
        end
      end else begin
        e_err  = (m_prog > 0);
        m_prog = (k == seq_key(0)) ? 1 : 0;
      end
    end else if (m_prog > 0) begin
      m_idle++;
      if (m_idle == TO_CYC) begin
        m_prog = 0; m_idle = 0;
      end
    end
  endtask

  // One cycle: clock edge, model update, then compare all outputs.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("det_pulse", det_pulse, e_pulse);
    chk("err_pulse", err_pulse, e_err);
    chk("det_led",   det_led,   e_led);
    chk("progress",  progress,  m_prog);
  endtask

  task automatic tap(input int k);
    btn_in[k] = 1'b1;
    step();
  endtask

  task automatic rel(input int n);
    btn_in = 8'h00;
    repeat (n) step();
  endtask

  initial begin
    int led_cnt;
    int r;
    int rate;
    rst_n  = 1'b0;
    btn_in = 8'h00;
    repeat (3) step();
    chk("reset progress", progress, 0);
    chk("reset det_led", det_led, 0);
    rst_n = 1'b1;
    step();

    // 1: full code 1,3,2,0
    tap(1); chk("t1 prog1", progress, 1); rel(2);
    tap(3); chk("t1 prog2", progress, 2); rel(2);
    tap(2); chk("t1 prog3", progress, 3); rel(2);
    tap(0);
    chk("t1 det_pulse", det_pulse, 1);
    chk("t1 det_led", det_led, 1);
    chk("t1 prog0", progress, 0);
    led_cnt = 1;
    btn_in = 8'h00;
    step();
    chk("t1 pulse one cycle", det_pulse, 0);
    if (det_led) led_cnt++;
    for (int i = 0; i < 40; i++) begin
      step();
      if (det_led) led_cnt++;
    end
    chk("t1 led cycles", led_cnt, 20);

    // 2: mismatch, then restart on first key
    tap(1); rel(2); tap(3); rel(2); tap(3);
    chk("t2 err", err_pulse, 1); chk("t2 prog0", progress, 0); rel(2);
    tap(1); rel(2); tap(1);
    chk("t2 restart err", err_pulse, 1); chk("t2 restart prog", progress, 1); rel(2);
    tap(6); chk("t2 wrong key prog", progress, 0); rel(2);

    // 3: timeout, then key in the timeout cycle
    tap(1); rel(99);
    chk("t3 before timeout", progress, 1);
    rel(1);
    chk("t3 timeout prog", progress, 0); chk("t3 timeout no err", err_pulse, 0);
    tap(1); repeat (99) step();
    chk("t3 held prog", progress, 1);
    btn_in[3] = 1'b1; step();
    chk("t3 key beats timeout", progress, 2);
    rel(2);

    // 4: two bits rise together at progress 2
    btn_in = 8'b0010_0100; step();
    chk("t4 multi err", err_pulse, 1); chk("t4 multi prog", progress, 0); rel(2);

    // 5: button held through reset
    btn_in = 8'h02; rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();
    chk("t5 no event", progress, 0); chk("t5 no err", err_pulse, 0);
    step();
    btn_in = 8'h00; step();
    tap(1); chk("t5 repress", progress, 1); rel(2);

    // 6: presses ignored in hold, reset mid-hold
    tap(3); rel(2); tap(2); rel(2); tap(0); chk("t6 det", det_pulse, 1); rel(3);
    tap(1); chk("t6 hold ignore", progress, 0); chk("t6 hold led", det_led, 1); rel(2);
    tap(3); chk("t6 hold ignore2", progress, 0); rel(1);
    rst_n = 1'b0; step();
    chk("t6 reset led", det_led, 0); chk("t6 reset prog", progress, 0);
    rst_n = 1'b1; step();

    // randomized activity in blocks of varying press rate
    for (int blk = 0; blk < 40; blk++) begin
      r = int'($urandom_range(0, 2));
      rate = (r == 0) ? 1 : ((r == 1) ? 6 : 40);
      for (int c = 0; c < 120; c++) begin
        r = int'($urandom_range(0, 999));
        rst_n = (r < 3) ? 1'b0 : 1'b1;
        r = int'($urandom_range(0, 99));
        if (r < rate) begin
          r = int'($urandom_range(0, 9));
          if (r < 5) btn_in = 8'h01 << seq_key(m_prog);
          else if (r < 8) btn_in[$urandom_range(0, 7)] = ~btn_in[$urandom_range(0, 7)];
          else btn_in = 8'($urandom);
        end
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
